rom_stream_fetcher: RTL and testbench

- Read controller that sits directly upstream of the ROM model and drives its rd_vld/rd_addr port.
- On start, it reads num_bytes consecutive bytes beginning at base_addr.
- It buffers the 1-cycle-latency returns in a byte FIFO and packs them LSB-first into PACK-byte words.
- Words are presented downstream on a valid/ready stream with a last flag.
- Read issue is credit-limited, so FIFO overflow cannot occur under downstream backpressure.

---
 rtl/rom_stream_fetcher.sv | 169 ++++++++++++++++
 tb/tb_rom_stream_fetcher.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_fetcher.sv
// Credit-limited ROM read controller: streams num_bytes consecutive ROM bytes
// through a small byte FIFO and packs them LSB-first into PACK-byte words.
module rom_stream_fetcher #(
    parameter int ADDR_WD    = 8,
    parameter int DATA_WD    = 8,
    parameter int PACK       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_WD-1:0]        base_addr,
    input  logic [ADDR_WD:0]          num_bytes,
    output logic                      busy,
    output logic                      done,
    output logic                      rom_rd_vld,
    output logic [ADDR_WD-1:0]        rom_rd_addr,
    input  logic [DATA_WD-1:0]        rom_rd_data,
    input  logic                      rom_rd_data_vld,
    output logic                      out_vld,
    output logic [DATA_WD*PACK-1:0]   out_data,
    output logic                      out_last,
    input  logic                      out_rdy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int NW = ADDR_WD + 1;

    if (PACK < 1 || PACK > 4 || FIFO_DEPTH < 2 * PACK) begin : g_param_check
        $error("rom_stream_fetcher: requires 1 <= PACK <= 4 and FIFO_DEPTH >= 2*PACK");
    end

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t               state;
    logic [DATA_WD-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        fifo_count;
    logic                 inflight;
    logic [ADDR_WD-1:0]   addr;
    logic [NW-1:0]        num_r, issued, returned, popped;

    logic                    push;
    int                      pop_n;
    logic                    can_issue;
    logic                    last_word;
    logic [DATA_WD*PACK-1:0] word;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= FIFO_DEPTH) s = s - FIFO_DEPTH;
        return PW'(s);
    endfunction

    always_comb begin
        push  = rom_rd_data_vld && inflight;
        pop_n = 0;
        if (state != IDLE && (!out_vld || out_rdy)) begin
            if (int'(fifo_count) >= PACK)
                pop_n = PACK;
            else if (returned == num_r && fifo_count != '0)
                pop_n = int'(fifo_count);
        end
        // Credit covers FIFO contents, the return landing now, the read on the
        // port and the one being decided, net of bytes leaving this cycle.
        can_issue = (state == FETCH) && (issued < num_r) &&
                    (int'(fifo_count) - pop_n + int'(inflight) + int'(rom_rd_vld) < FIFO_DEPTH);
        last_word = (int'(popped) + pop_n == int'(num_r));
        word = '0;
        for (int i = 0; i < PACK; i++) begin
            if (i < pop_n) word[i*DATA_WD +: DATA_WD] = mem[ptr_add(rd_ptr, i)];
        end
    end

    // NOTE: storage has no reset; fifo_count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rom_rd_data;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            inflight    <= 1'b0;
            addr        <= '0;
            num_r       <= '0;
            issued      <= '0;
            returned    <= '0;
            popped      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_rd_vld  <= 1'b0;
            rom_rd_addr <= '0;
            out_vld     <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= rom_rd_vld;

            if (push) begin
                wr_ptr   <= ptr_add(wr_ptr, 1);
                returned <= returned + 1'b1;
            end
            rd_ptr     <= ptr_add(rd_ptr, pop_n);
            fifo_count <= CW'(int'(fifo_count) + int'(push) - pop_n);
            popped     <= popped + NW'(pop_n);

            if (pop_n != 0) begin
                out_vld  <= 1'b1;
                out_data <= word;
                out_last <= last_word;
            end else if (out_vld && out_rdy) begin
                out_vld  <= 1'b0;
                out_data <= '0;
                out_last <= 1'b0;
            end

            case (state)
                IDLE: begin
                    rom_rd_vld <= 1'b0;
                    if (start) begin
                        if (num_bytes != '0) begin
                            // The first read goes out with the state change.
                            num_r       <= num_bytes;
                            rom_rd_vld  <= 1'b1;
                            rom_rd_addr <= base_addr;
                            addr        <= base_addr + 1'b1;
                            issued      <= NW'(1);
                            returned    <= '0;
                            popped      <= '0;
                            busy        <= 1'b1;
                            state       <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    rom_rd_vld <= can_issue;
                    if (can_issue) begin
                        rom_rd_addr <= addr;
                        addr        <= addr + 1'b1;
                        issued      <= issued + 1'b1;
                    end
                    if (issued == num_r || (can_issue && issued + 1'b1 == num_r))
                        state <= DRAIN;
                end
                DRAIN: begin
                    rom_rd_vld <= 1'b0;
                    if (out_vld && out_rdy && out_last &&
                        returned == num_r && fifo_count == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_fetcher.sv
// Self-checking bench: a ROM model plus a transfer-level reference model
// (expected read addresses and packed words) compared every cycle.
module tb_rom_stream_fetcher;

    localparam int ADDR_WD = 8;
    localparam int DATA_WD = 8;
    localparam int PACK    = 2;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  num_bytes = '0;
    logic        busy, done, rom_rd_vld, out_vld, out_last;
    logic [7:0]  rom_rd_addr;
    logic [7:0]  rom_rd_data = '0;
    logic        rom_rd_data_vld = 1'b0;
    logic [15:0] out_data;
    logic        out_rdy = 1'b1;

    rom_stream_fetcher #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .PACK(PACK), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_bytes(num_bytes), .busy(busy), .done(done), .rom_rd_vld(rom_rd_vld),
        .rom_rd_addr(rom_rd_addr), .rom_rd_data(rom_rd_data),
        .rom_rd_data_vld(rom_rd_data_vld), .out_vld(out_vld), .out_data(out_data),
        .out_last(out_last), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    // ROM model with one-cycle read latency; 'spurious' forces an unrequested return.
    logic [7:0] rom [256];
    logic       spurious = 1'b0;
    always @(posedge clk) begin
        rom_rd_data     <= rom[rom_rd_addr];
        rom_rd_data_vld <= rom_rd_vld | spurious;
    end

    int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = ($urandom_range(0, 3) != 0);
            default: out_rdy = 1'b0;
        endcase
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int limit);
        vectors++;
        if (act > limit) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected at most %0d", name, act, limit);
        end
    endtask

    // Reference model state
    typedef struct packed { logic [15:0] data; logic last; } word_t;
    word_t      exp_words[$];
    logic [7:0] exp_addr[$];
    logic [7:0] addr_log[$];
    logic [15:0] acc_log[$];
    logic exp_busy = 1'b0, exp_done = 1'b0, exp_zero = 1'b0;
    bit   mon_en = 1'b0;
    int   cyc = 0, cyc0 = 0, rd_count = 0, acc_bytes = 0;
    int   first_vld_rel = -1, done_rel = -1, done_cnt = 0;

    always @(negedge clk) begin
        logic nb, nd;
        word_t w;
        cyc++;
        if (mon_en) begin
            if (exp_zero) begin
                check("rst_busy", 32'(busy), 0);
                check("rst_done", 32'(done), 0);
                check("rst_rd_vld", 32'(rom_rd_vld), 0);
                check("rst_rd_addr", 32'(rom_rd_addr), 0);
                check("rst_out_vld", 32'(out_vld), 0);
                check("rst_out_data", 32'(out_data), 0);
                check("rst_out_last", 32'(out_last), 0);
            end
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            if (exp_done) check("reads_complete", 32'(exp_addr.size()), 0);
            if (done) begin
                done_cnt++;
                done_rel = cyc - cyc0;
            end
            if (rom_rd_vld) begin
                addr_log.push_back(rom_rd_addr);
                rd_count++;
                if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", 32'(rom_rd_addr), 32'(exp_addr.pop_front()));
                check_le("read_ahead", rd_count - acc_bytes, DEPTH + PACK);
            end
            if (out_vld) begin
                if (first_vld_rel < 0) first_vld_rel = cyc - cyc0;
                if (exp_words.size() == 0) check("out_unexpected", 1, 0);
                else begin
                    check("out_data", 32'(out_data), 32'(exp_words[0].data));
                    check("out_last", 32'(out_last), 32'(exp_words[0].last));
                end
            end else begin
                check("out_data_idle", 32'(out_data), 0);
            end

            // Expectations for the next cycle
            nb = exp_busy;
            nd = 1'b0;
            exp_zero = 1'b0;
            if (!reset_n) begin
                exp_zero = 1'b1;
                nb = 1'b0;
                exp_words.delete();
                exp_addr.delete();
            end else begin
                if (out_vld && out_rdy && exp_words.size() > 0) begin
                    w = exp_words.pop_front();
                    acc_log.push_back(out_data);
                    acc_bytes += PACK;
                    if (w.last) begin
                        nd = 1'b1;
                        nb = 1'b0;
                    end
                end
                if (!exp_busy && start) begin
                    cyc0 = cyc;
                    rd_count = 0;
                    acc_bytes = 0;
                    first_vld_rel = -1;
                    if (num_bytes == 0) nd = 1'b1;
                    else begin
                        nb = 1'b1;
                        for (int k = 0; k < int'(num_bytes); k++)
                            exp_addr.push_back(8'(int'(base_addr) + k));
                        for (int wi = 0; wi * PACK < int'(num_bytes); wi++) begin
                            w = '0;
                            for (int b = 0; b < PACK; b++)
                                if (wi * PACK + b < int'(num_bytes))
                                    w.data[b*8 +: 8] = rom[8'(int'(base_addr) + wi * PACK + b)];
                            w.last = ((wi + 1) * PACK >= int'(num_bytes));
                            exp_words.push_back(w);
                        end
                    end
                end
            end
            exp_busy = nb;
            exp_done = nd;
        end
    end

    task automatic start_xfer(input logic [7:0] b, input logic [8:0] n);
        @(posedge clk); #1;
        base_addr = b;
        num_bytes = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                #1;
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic idle_spurious();
        @(posedge clk); #1;
        rom_rd_data_vld = rom_rd_data_vld;
        spurious = 1'b1;
        @(posedge clk); #1;
        spurious = 1'b0;
    endtask

    initial begin
        int a0, w0, dc;
        logic [7:0] rb;
        logic [8:0] rn;

        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h09; rom[1] = 8'h3F; rom[2] = 8'hCC; rom[3] = 8'hCC; rom[4] = 8'hCD;
        rom[255] = 8'hA5;

        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic four-byte transfer
        w0 = acc_log.size(); dc = done_cnt;
        start_xfer(8'h00, 9'd4);
        wait_done(200);
        check("t1_word0", 32'(acc_log[w0]), 32'h3F09);
        check("t1_word1", 32'(acc_log[w0+1]), 32'hCCCC);
        check("t1_first_vld_cycle", 32'(first_vld_rel), 32'(PACK + 3));
        check("t1_done_count", 32'(done_cnt - dc), 1);

        // Odd count: zero-filled tail word
        w0 = acc_log.size(); a0 = addr_log.size();
        start_xfer(8'h02, 9'd3);
        wait_done(200);
        check("t2_reads", 32'(rd_count), 3);
        check("t2_addr0", 32'(addr_log[a0]), 2);
        check("t2_addr1", 32'(addr_log[a0+1]), 3);
        check("t2_addr2", 32'(addr_log[a0+2]), 4);
        check("t2_word0", 32'(acc_log[w0]), 32'hCCCC);
        check("t2_word1", 32'(acc_log[w0+1]), 32'h00CD);

        // Downstream stall bounds read-ahead
        w0 = acc_log.size(); dc = done_cnt;
        rdy_mode = 2;
        start_xfer(8'h00, 9'd20);
        repeat (30) @(posedge clk);
        check_le("t3_stall_reads", rd_count, DEPTH + PACK);
        check("t3_stall_out_vld", 32'(out_vld), 1);
        rdy_mode = 0;
        wait_done(400);
        check("t3_words", 32'(acc_log.size() - w0), 10);
        check("t3_done_count", 32'(done_cnt - dc), 1);

        // Zero-length transfer
        idle_spurious();
        dc = done_cnt; w0 = acc_log.size();
        start_xfer(8'h10, 9'd0);
        wait_done(20);
        check("t4_done_latency", 32'(done_rel), 1);
        check("t4_reads", 32'(rd_count), 0);
        check("t4_words", 32'(acc_log.size() - w0), 0);
        check("t4_done_count", 32'(done_cnt - dc), 1);

        // Address wrap
        w0 = acc_log.size(); a0 = addr_log.size();
        start_xfer(8'hFF, 9'd2);
        wait_done(200);
        check("t5_addr0", 32'(addr_log[a0]), 32'hFF);
        check("t5_addr1", 32'(addr_log[a0+1]), 32'h00);
        check("t5_word", 32'(acc_log[w0]), 32'h09A5);

        // Reset mid-FETCH aborts without done
        dc = done_cnt;
        start_xfer(8'h10, 9'd20);
        for (int i = 0; i < 50 && rd_count < 3; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        spurious = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        spurious = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_done", 32'(done_cnt - dc), 0);
        w0 = acc_log.size();
        start_xfer(8'h40, 9'd6);
        wait_done(200);
        check("t6_words", 32'(acc_log.size() - w0), 3);
        check("t6_word0", 32'(acc_log[w0]), 32'({rom[8'h41], rom[8'h40]}));

        // Randomized transfers under random backpressure
        for (int t = 0; t < 14; t++) begin
            rb = 8'($urandom_range(0, 255));
            rn = (t == 5) ? 9'd256 : 9'($urandom_range(0, 48));
            rdy_mode = (t % 3 == 0) ? 0 : 1;
            if ($urandom_range(0, 1) == 1) idle_spurious();
            dc = done_cnt; w0 = acc_log.size();
            start_xfer(rb, rn);
            wait_done(3000);
            check("rand_words", 32'(acc_log.size() - w0), 32'((int'(rn) + PACK - 1) / PACK));
            check("rand_done_count", 32'(done_cnt - dc), 1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_words_empty", 32'(exp_words.size()), 0);
        check("final_addr_empty", 32'(exp_addr.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
